// File: rtl/nmr_acq_pkg.sv
// rtl/nmr_acq_pkg.sv - shared types and constants for the NMR echo capture block
package nmr_acq_pkg;

  localparam int DEF_ADC_WIDTH        = 16;
  localparam int DEF_FIFO_AW          = 10;
  localparam int DEF_SAMPLE_CNT_WIDTH = 16;
  localparam int DEF_ECHO_CNT_WIDTH   = 32;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_ARMED   = 4'b0010,
    ST_CAPTURE = 4'b0100,
    ST_FLUSH   = 4'b1000
  } cap_state_e;

  // FIFO word is {LAST, DATA}
  function automatic int fifo_word_width(input int adc_width);
    return adc_width + 1;
  endfunction

endpackage

// File: rtl/nmr_sync_fifo.sv
// rtl/nmr_sync_fifo.sv - single-clock first-word-fall-through FIFO with level output
module nmr_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = level_q[AW];
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO lands in the slot freed by a same-cycle pop
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/nmr_echo_capture.sv
// rtl/nmr_echo_capture.sv - samples ADC data inside sequencer acquisition windows,
// tags the last sample of each echo and streams it out through a FWFT FIFO
module nmr_echo_capture
  import nmr_acq_pkg::*;
#(
  parameter int ADC_WIDTH        = DEF_ADC_WIDTH,
  parameter int FIFO_AW          = DEF_FIFO_AW,
  parameter int SAMPLE_CNT_WIDTH = DEF_SAMPLE_CNT_WIDTH,
  parameter int ECHO_CNT_WIDTH   = DEF_ECHO_CNT_WIDTH
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        FSMSTAT,
  input  logic                        ACQ_WND,
  input  logic                        ADC_CLK,
  input  logic [ADC_WIDTH-1:0]        ADC_DATA,
  input  logic                        CLR,
  output logic [ADC_WIDTH-1:0]        OUT_DATA,
  output logic                        OUT_LAST,
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic [ECHO_CNT_WIDTH-1:0]   ECHO_CNT,
  output logic [SAMPLE_CNT_WIDTH-1:0] SAMPLE_CNT,
  output logic [FIFO_AW:0]            FIFO_LEVEL,
  output logic                        OVERFLOW,
  output logic                        BUSY
);

  localparam int WORD_W = fifo_word_width(ADC_WIDTH);

  // sync vectors are {adc_clk, acq_wnd, fsmstat}
  logic [2:0]                  sync1_q, sync2_q;
  logic [ADC_WIDTH-1:0]        data_q;
  logic [1:0]                  fill_q, fill_d;
  cap_state_e                  state_q, state_d;
  logic [ADC_WIDTH-1:0]        pend_q, pend_d;
  logic                        pend_valid_q, pend_valid_d;
  logic [SAMPLE_CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic [SAMPLE_CNT_WIDTH-1:0] sample_cnt_q, sample_cnt_d;
  logic [ECHO_CNT_WIDTH-1:0]   echo_cnt_q, echo_cnt_d;
  logic                        overflow_q, overflow_d;

  logic              strobe, wnd_open, wclose, fsm_on, fsm_rise;
  logic              push, push_last, pop;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_rdata;

  assign strobe   = sync2_q[2] & ~sync1_q[2];
  assign wnd_open = sync1_q[1];
  assign wclose   = sync2_q[1] & ~sync1_q[1];
  assign fsm_on   = sync1_q[0];
  // fill_q keeps the reset value of the sync chain from posing as a rising edge
  assign fsm_rise = fill_q[1] & sync1_q[0] & ~sync2_q[0];
  assign pop      = ~fifo_empty & OUT_READY;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    run_cnt_d    = run_cnt_q;
    sample_cnt_d = sample_cnt_q;
    echo_cnt_d   = echo_cnt_q;
    overflow_d   = overflow_q;
    fill_d       = {fill_q[0], 1'b1};
    push         = 1'b0;
    push_last    = 1'b0;
    if (CLR) begin
      state_d      = ST_IDLE;
      pend_d       = '0;
      pend_valid_d = 1'b0;
      run_cnt_d    = '0;
      sample_cnt_d = '0;
      echo_cnt_d   = '0;
      overflow_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fsm_rise) begin
            state_d      = ST_ARMED;
            echo_cnt_d   = '0;
            sample_cnt_d = '0;
            overflow_d   = 1'b0;
          end
        end
        ST_ARMED: begin
          if (!fsm_on)       state_d = ST_IDLE;
          else if (wnd_open) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (wclose || !fsm_on) begin
            state_d = ST_FLUSH;
          end else if (strobe && wnd_open) begin
            push         = pend_valid_q;
            pend_d       = data_q;
            pend_valid_d = 1'b1;
            if (run_cnt_q != '1) run_cnt_d = run_cnt_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (pend_valid_q) begin
            push         = 1'b1;
            push_last    = 1'b1;
            echo_cnt_d   = echo_cnt_q + 1'b1;
            sample_cnt_d = run_cnt_q;
          end
          pend_valid_d = 1'b0;
          run_cnt_d    = '0;
          state_d      = fsm_on ? ST_ARMED : ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (push && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      data_q       <= '0;
      fill_q       <= '0;
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      run_cnt_q    <= '0;
      sample_cnt_q <= '0;
      echo_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      sync1_q      <= {ADC_CLK, ACQ_WND, FSMSTAT};
      sync2_q      <= sync1_q;
      data_q       <= ADC_DATA;
      fill_q       <= fill_d;
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      run_cnt_q    <= run_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      echo_cnt_q   <= echo_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  nmr_sync_fifo #(
    .WIDTH (WORD_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (CLK),
    .reset (RESET),
    .clr   (CLR),
    .push  (push),
    .wdata ({push_last, pend_q}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (FIFO_LEVEL)
  );

  assign OUT_VALID  = ~fifo_empty;
  assign OUT_DATA   = fifo_empty ? '0 : fifo_rdata[ADC_WIDTH-1:0];
  assign OUT_LAST   = ~fifo_empty & fifo_rdata[ADC_WIDTH];
  assign ECHO_CNT   = echo_cnt_q;
  assign SAMPLE_CNT = sample_cnt_q;
  assign OVERFLOW   = overflow_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: doc/nmr_echo_capture.md
Name: nmr_echo_capture

Overview:
Receive-side counterpart of the NMR pulse-program sequencer. Consumes the sequencer's FSMSTAT, ACQ_WND and ADC_CLK together with parallel ADC data. Samples the ADC once per ADC_CLK period while the acquisition window is open and tags the final sample of each echo. Buffers samples in an on-chip FIFO and streams them to the host/DMA side over a valid/ready interface, with per-scan echo and sample statistics.

Parameters:
ADC_WIDTH, 16, ADC sample width in bits
FIFO_AW, 10, FIFO address width; depth = 2^FIFO_AW words
SAMPLE_CNT_WIDTH, 16, width of the per-echo sample counter
ECHO_CNT_WIDTH, 32, width of the per-scan echo counter

Ports:
CLK  in  1  system clock; same clock as the sequencer
RESET  in  1  asynchronous, active-high reset
FSMSTAT  in  1  sequencer busy; high for the whole scan
ACQ_WND  in  1  acquisition window from the sequencer
ADC_CLK  in  1  ADC clock, generated synchronously to CLK (CLK/4)
ADC_DATA  in  ADC_WIDTH  ADC output word, stable around the ADC_CLK falling edge
CLR  in  1  synchronous clear of FIFO, counters and OVERFLOW
OUT_DATA  out  ADC_WIDTH  FIFO head sample
OUT_LAST  out  1  head sample is the last sample of its echo
OUT_VALID  out  1  FIFO not empty
OUT_READY  in  1  consumer accepts the head word
ECHO_CNT  out  ECHO_CNT_WIDTH  echoes completed in the current/last scan
SAMPLE_CNT  out  SAMPLE_CNT_WIDTH  sample count of the most recently closed echo
FIFO_LEVEL  out  FIFO_AW+1  words currently stored
OVERFLOW  out  1  sticky: at least one sample dropped because the FIFO was full
BUSY  out  1  capture FSM is not IDLE

Behaviour:
- Reset and CLR: all outputs 0; FIFO empty; FSM in IDLE; PENDING_VALID = 0. CLR has priority over all other events in the same cycle.
- Input stage: ADC_CLK, ACQ_WND, FSMSTAT and ADC_DATA are registered twice (q1, q2).
- STROBE = q2(ADC_CLK) & ~q1(ADC_CLK), i.e. falling edge. Sample value = q1(ADC_DATA).
- Window open = q1(ACQ_WND). WCLOSE = q2(ACQ_WND) & ~q1(ACQ_WND).
- FSM states: IDLE, ARMED, CAPTURE, FLUSH.
  - IDLE -> ARMED on the FSMSTAT rising edge. On that edge, clear ECHO_CNT, SAMPLE_CNT and OVERFLOW; the FIFO is not cleared.
  - ARMED -> CAPTURE when the window opens. ARMED -> IDLE when FSMSTAT falls.
  - CAPTURE: on each STROBE with the window open:
    - if PENDING_VALID, write PENDING to the FIFO with LAST = 0;
    - load the new sample into PENDING and set PENDING_VALID;
    - increment the running sample counter, saturating at all-ones.
  - CAPTURE -> FLUSH on WCLOSE, or on the FSMSTAT fall if the window is still open.
  - FLUSH (one cycle):
    - if PENDING_VALID, write PENDING with LAST = 1, increment ECHO_CNT (wraps), and copy the running counter to SAMPLE_CNT;
    - clear PENDING_VALID and the running counter;
    - next state is ARMED, or IDLE if FSMSTAT is low.
  - A window containing zero strobes produces no FIFO word and does not increment ECHO_CNT.
  - A STROBE in the same cycle as WCLOSE is ignored, because the window is already closed.
- Latency:
  - A sample is written to the FIFO on the cycle of the next STROBE, or in the FLUSH cycle.
  - OUT_VALID rises one CLK after a write into an empty FIFO.
- FIFO: synchronous, first-word-fall-through.
  - Pop when OUT_VALID & OUT_READY.
  - Push while full is accepted only if a pop occurs in the same cycle. Otherwise the word is dropped and OVERFLOW is set. A dropped LAST word still counts toward ECHO_CNT.
  - Simultaneous push and pop leaves FIFO_LEVEL unchanged.
  - OUT_DATA and OUT_LAST hold while OUT_VALID is high and OUT_READY is low.
- The FIFO keeps draining in IDLE. BUSY does not depend on FIFO contents.
- RESET mid-scan: capture stops immediately and FIFO contents are lost. After RESET is released, the FSM stays in IDLE until the next FSMSTAT rising edge; a scan already in progress is not resumed.

Decomposition:
- Package nmr_acq_pkg:
  - capture FSM state enum (one-hot, 4 states);
  - FIFO word layout {LAST, DATA} and its width, ADC_WIDTH+1;
  - default parameter constants.
- Sub-module nmr_sync_fifo: parameterised single-clock FWFT FIFO with push/pop/full/empty/level and async RESET. It is instantiated once. All other logic lives in the top module.

Test Plan:
- ADC_CLK = CLK/4, ADC_DATA ramps +1 per ADC_CLK, one 40-CLK window, OUT_READY = 1 -> 10 words in ramp order, only the 10th has OUT_LAST = 1, SAMPLE_CNT = 10, ECHO_CNT = 1.
- Scan with 4 echoes of 10 samples each -> 40 words, OUT_LAST on words 10/20/30/40, ECHO_CNT = 4, BUSY low 2 CLK after FSMSTAT falls.
- FIFO_AW = 3, OUT_READY = 0, 12-sample window -> FIFO_LEVEL = 8, OVERFLOW = 1, first 8 samples retained; OVERFLOW clears on CLR or the next FSMSTAT rise.
- Window shorter than one ADC_CLK period (2 CLK, no falling edge inside) -> no FIFO word, ECHO_CNT stays 0.
- FIFO full with OUT_READY = 1 on the same cycle as a push -> word accepted, FIFO_LEVEL unchanged, OVERFLOW stays 0.
- RESET asserted mid-window -> all outputs 0 within the same cycle; after release, no capture until a new FSMSTAT rising edge.
